// File: rtl/common_pkg.sv
// Shared bus types used across the core.
// ibus_req_t  : instruction bus request (valid, addr, size, wr).
// ibus_resp_t : instruction bus response (data_ok, data).
package common;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        wr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-stage types for the front end.
// fetch_entry_t : one queued fetch result {pc, instr}, 96 bits.
// ifq_state_e   : fetch-queue sequencer states.
package pipes;

  localparam int unsigned FETCH_ENTRY_W = 96;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,   // idle, may issue the next request
    WAIT  = 2'd1,   // request outstanding, response will be kept
    DRAIN = 2'd2    // request outstanding, response will be dropped
  } ifq_state_e;

endpackage

// File: rtl/ifq_ram.sv
// Fetch-queue storage: DEPTH x 96-bit register array.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write slot
//   wdata_i  - entry to write
//   raddr_i  - read slot
//   rdata_o  - entry at raddr_i (asynchronous read)
// Contents are not reset; validity is tracked by the controller.
module ifq_ram
  import pipes::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_entry_t  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_entry_t  rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one instruction-bus request at a time,
// buffers up to DEPTH {pc, instr} results and presents the oldest one to
// the decoder with a valid/ready handshake. A redirect flushes the queue
// and restarts fetching at redirect_pc.
// Parameters:
//   DEPTH    - queue entries (power of two, 2..16)
//   RESET_PC - fetch address after reset
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   ireq / iresp    - instruction bus request / response
//   redirect_valid  - flush and refetch from redirect_pc
//   redirect_pc     - new fetch address (used unmodified)
//   out_valid/ready - head-entry handshake
//   out_pc/instr    - head entry
// Build option:
//   IFQ_BYPASS_EN   - forward an accepted response straight to the output
//                     when the queue is empty (same-cycle out_valid).
module ifetch_queue
  import common::*;
  import pipes::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  ifq_state_e   state_q;
  logic [63:0]  fetch_pc_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic         req_valid_q;
  logic [63:0]  req_addr_q;

  logic         q_valid, pop_now, accept, push, issue;
  fetch_entry_t wr_entry, rd_entry;

  assign q_valid  = (count_q != '0);
  // A redirect wipes the queue, so a simultaneous handshake must not move rptr.
  assign pop_now  = q_valid & out_ready & ~redirect_valid;
  assign accept   = (state_q == WAIT) & iresp.data_ok & ~redirect_valid;
  assign wr_entry = '{pc: req_addr_q, instr: iresp.data};
  // One request in flight at most, and only when a slot is free for it,
  // so a push can never find the queue full.
  assign issue    = (state_q == FETCH) & ~redirect_valid &
                    ((count_q + CW'(pop_now)) < CW'(DEPTH));

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass    = accept & ~q_valid;
  // A bypassed entry taken the same cycle never touches storage.
  assign push      = accept & ~(bypass & out_ready);
  assign out_valid = q_valid | bypass;
  assign out_pc    = q_valid ? rd_entry.pc    : req_addr_q;
  assign out_instr = q_valid ? rd_entry.instr : iresp.data;
`else
  assign push      = accept;
  assign out_valid = q_valid;
  assign out_pc    = rd_entry.pc;
  assign out_instr = rd_entry.instr;
`endif

  always_comb begin
    ireq       = '0;
    ireq.valid = req_valid_q;
    ireq.addr  = req_addr_q;
  end

  ifq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      // queue bookkeeping
      if (redirect_valid) begin
        count_q <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
      end else begin
        if (push)    wptr_q <= wptr_q + 1'b1;
        if (pop_now) rptr_q <= rptr_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop_now);
      end

      if (redirect_valid)  fetch_pc_q <= redirect_pc;
      else if (accept)     fetch_pc_q <= fetch_pc_q + 64'd4;

      // request sequencer; ireq.addr only moves while no request is live
      case (state_q)
        FETCH: begin
          if (redirect_valid) begin
            // preload so the new target shows on the bus next cycle
            req_addr_q <= redirect_pc;
          end else if (issue) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b1;
            req_addr_q  <= fetch_pc_q;
          end
        end
        WAIT: begin
          if (iresp.data_ok) begin
            state_q     <= FETCH;
            req_valid_q <= 1'b0;
            if (redirect_valid) req_addr_q <= redirect_pc;
          end else if (redirect_valid) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (iresp.data_ok) begin
            state_q     <= FETCH;
            req_valid_q <= 1'b0;
            if (redirect_valid) req_addr_q <= redirect_pc;
          end
        end
        default: begin
          state_q     <= FETCH;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
